// File: rtl/rams_sdp_arb_pkg.sv
// Requester ids and arbiter reset state shared by the SDP RAM arbiter files.
package rams_sdp_arb_pkg;
    localparam logic REQ_M0  = 1'b0;
    localparam logic REQ_M1  = 1'b1;
    localparam logic PTR_RST = REQ_M0;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
    import rams_sdp_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt = req;
        if (req[0] && req[1])
            gnt = (ptr == REQ_M0) ? 2'b01 : 2'b10;
    end

    // Priority passes to whoever just lost (or was idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr <= PTR_RST;
        else if (gnt[0]) ptr <= REQ_M1;
        else if (gnt[1]) ptr <= REQ_M0;
    end
endmodule

// File: rtl/rams_sdp_arbiter.sv
// Two-requester front end for a simple-dual-port RAM: write port A and read port B
// are arbitrated independently; same-cycle same-address write/read is bypassed.
module rams_sdp_arbiter
    import rams_sdp_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);
    logic [1:0]            wreq, rreq, wgnt, rgnt;
    logic                  w_any, r_any, byp_now;
    logic [ADDR_WIDTH-1:0] addra_q, addrb_q;
    logic [DATA_WIDTH-1:0] dia_q;
    logic                  rd_pend, rd_id, byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;

    assign wreq = {m1_req_valid &  m1_req_we, m0_req_valid &  m0_req_we};
    assign rreq = {m1_req_valid & ~m1_req_we, m0_req_valid & ~m0_req_we};

    rr_arb2 u_warb (.clk(clk), .rst(rst), .req(wreq), .gnt(wgnt));
    rr_arb2 u_rarb (.clk(clk), .rst(rst), .req(rreq), .gnt(rgnt));

    assign w_any        = |wgnt;
    assign r_any        = |rgnt;
    assign m0_req_ready = wgnt[0] | rgnt[0];
    assign m1_req_ready = wgnt[1] | rgnt[1];

    // Idle ports replay the last granted address/data so the RAM pins stay quiet.
    always_comb begin
        ram_ena   = w_any;
        ram_wea   = w_any;
        ram_enb   = r_any;
        ram_addra = addra_q;
        ram_dia   = dia_q;
        ram_addrb = addrb_q;
        if (wgnt[0]) begin
            ram_addra = m0_req_addr;
            ram_dia   = m0_req_wdata;
        end else if (wgnt[1]) begin
            ram_addra = m1_req_addr;
            ram_dia   = m1_req_wdata;
        end
        if (rgnt[0])      ram_addrb = m0_req_addr;
        else if (rgnt[1]) ram_addrb = m1_req_addr;
    end

    // The RAM returns pre-write data on a collision, so the new word is kept here.
    assign byp_now = w_any && r_any && (ram_addra == ram_addrb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addra_q  <= '0;
            addrb_q  <= '0;
            dia_q    <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= REQ_M0;
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            if (w_any) begin
                addra_q <= ram_addra;
                dia_q   <= ram_dia;
            end
            if (r_any) begin
                addrb_q <= ram_addrb;
                rd_id   <= rgnt[1] ? REQ_M1 : REQ_M0;
            end
            rd_pend <= r_any;
            byp_hit <= byp_now;
            if (byp_now) byp_data <= ram_dia;
        end
    end

    assign m0_rsp_valid = rd_pend && (rd_id == REQ_M0);
    assign m1_rsp_valid = rd_pend && (rd_id == REQ_M1);
    assign m0_rsp_rdata = byp_hit ? byp_data : ram_dob;
    assign m1_rsp_rdata = byp_hit ? byp_data : ram_dob;
endmodule

// File: tb/tb_rams_sdp_arbiter.sv
// Directed bench for rams_sdp_arbiter with a read-first SDP RAM model attached.
module tb_rams_sdp_arbiter;
    logic        clk, rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [9:0]  m0_req_addr;
    logic [31:0] m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [9:0]  m1_req_addr;
    logic [31:0] m1_req_wdata, m1_rsp_rdata;
    logic        ram_ena, ram_wea, ram_enb;
    logic [9:0]  ram_addra, ram_addrb;
    logic [31:0] ram_dia, ram_dob;
    int checks, errors;

    rams_sdp_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    // RAM model: read-first, registered read, synchronous clear of dob.
    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (rst)          ram_dob <= 32'h0;
        else if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
        m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
    endtask

    task automatic set_m1(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
        m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    logic [9:0]  wa0 [0:3] = '{10'h020, 10'h021, 10'h040, 10'h000};
    logic [31:0] wd0 [0:3] = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hC0C0_0040, 32'h0};
    logic [9:0]  wa1 [0:3] = '{10'h030, 10'h031, 10'h040, 10'h000};
    logic [31:0] wd1 [0:3] = '{32'hB0B0_0000, 32'hB1B1_0001, 32'hC1C1_0040, 32'h0};
    logic [9:0]  exp_wa [0:5] = '{10'h020, 10'h030, 10'h021, 10'h031, 10'h040, 10'h040};
    logic [31:0] exp_rd [0:5] = '{32'hA0A0_0000, 32'hB0B0_0000, 32'hA1A1_0001,
                                  32'hB1B1_0001, 32'hC1C1_0040, 32'hC1C1_0040};

    initial begin
        int i0, i1;
        logic [1:0] eg;
        checks = 0; errors = 0;
        rst = 1'b1;
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {30'h0, m1_req_ready, m0_req_ready}, 32'h0);
        check("rst_en",     {29'h0, ram_ena, ram_wea, ram_enb}, 32'h0);
        check("rst_addra",  {22'h0, ram_addra}, 32'h0);
        check("rst_addrb",  {22'h0, ram_addrb}, 32'h0);
        check("rst_dia",    ram_dia, 32'h0);
        check("rst_rspv",   {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h0);
        next_cyc(); rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_rspv", {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h0);
        end

        // m0 write then m1 read of the same word through the RAM
        next_cyc(); set_m0(1, 1, 10'h005, 32'hDEADBEEF);
        @(negedge clk);
        check("w5_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h1);
        check("w5_en",    {29'h0, ram_ena, ram_wea, ram_enb}, 32'h6);
        check("w5_addra", {22'h0, ram_addra}, 32'h005);
        check("w5_dia",   ram_dia, 32'hDEADBEEF);
        next_cyc(); set_m0(0, 0, 0, 0); set_m1(1, 0, 10'h005, 0);
        @(negedge clk);
        check("r5_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h2);
        check("r5_en",    {29'h0, ram_ena, ram_wea, ram_enb}, 32'h1);
        check("r5_addrb", {22'h0, ram_addrb}, 32'h005);
        check("r5_addra_hold", {22'h0, ram_addra}, 32'h005);
        next_cyc(); set_m1(0, 0, 0, 0);
        @(negedge clk);
        check("r5_rspv",  {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h2);
        check("r5_rdata", m1_rsp_rdata, 32'hDEADBEEF);

        // same-cycle write/read of 0x3FF: bypass, then RAM read
        next_cyc(); set_m0(1, 1, 10'h3FF, 32'h12345678); set_m1(1, 0, 10'h3FF, 0);
        @(negedge clk);
        check("byp_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h3);
        next_cyc(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        @(negedge clk);
        check("byp_rspv",  {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h2);
        check("byp_rdata", m1_rsp_rdata, 32'h12345678);
        next_cyc(); set_m0(1, 0, 10'h3FF, 0);
        @(negedge clk);
        check("r3ff_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h1);
        next_cyc(); set_m0(0, 0, 0, 0);
        @(negedge clk);
        check("r3ff_rspv",  {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h1);
        check("r3ff_rdata", m0_rsp_rdata, 32'h12345678);

        // preload 0x011 for the no-bypass case
        next_cyc(); set_m1(1, 1, 10'h011, 32'h11111111);
        @(negedge clk);
        check("w11_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h2);

        // reset while a read is in flight drops its response
        next_cyc(); set_m1(0, 0, 0, 0); set_m0(1, 0, 10'h005, 0);
        @(negedge clk);
        check("rr_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h1);
        rst = 1'b1;
        next_cyc(); set_m0(0, 0, 0, 0);
        @(negedge clk);
        check("rr_rspv_in_rst", {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h0);
        next_cyc(); rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rr_rspv_after", {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h0);
        end

        // contested writes alternate m0, m1, ... with losers holding
        i0 = 0; i1 = 0;
        for (int c = 0; c < 6; c++) begin
            next_cyc();
            set_m0(i0 < 3, 1, wa0[i0], wd0[i0]);
            set_m1(i1 < 3, 1, wa1[i1], wd1[i1]);
            @(negedge clk);
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            check("wc_grant", {30'h0, m1_req_ready, m0_req_ready}, {30'h0, eg});
            check("wc_addra", {22'h0, ram_addra}, {22'h0, exp_wa[c]});
            if (m0_req_ready) i0++;
            if (m1_req_ready) i1++;
        end

        // contested reads alternate m0, m1, ...; response lands on the issuer
        i0 = 0; i1 = 0;
        for (int c = 0; c < 7; c++) begin
            next_cyc();
            set_m0(i0 < 3, 0, wa0[i0], 0);
            set_m1(i1 < 3, 0, wa1[i1], 0);
            @(negedge clk);
            if (c < 6) begin
                eg = (c % 2 == 0) ? 2'b01 : 2'b10;
                check("rc_grant", {30'h0, m1_req_ready, m0_req_ready}, {30'h0, eg});
            end
            if (c > 0) begin
                eg = ((c - 1) % 2 == 0) ? 2'b01 : 2'b10;
                check("rc_rspv", {30'h0, m1_rsp_valid, m0_rsp_valid}, {30'h0, eg});
                check("rc_rdata", eg[0] ? m0_rsp_rdata : m1_rsp_rdata, exp_rd[c-1]);
            end
            if (m0_req_ready) i0++;
            if (m1_req_ready) i1++;
        end

        // different addresses in the same cycle: no bypass, old data returned
        next_cyc(); set_m0(1, 1, 10'h010, 32'h99999999); set_m1(1, 0, 10'h011, 0);
        @(negedge clk);
        check("nb_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h3);
        check("nb_en",    {29'h0, ram_ena, ram_wea, ram_enb}, 32'h7);
        next_cyc(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        @(negedge clk);
        check("nb_rspv",  {30'h0, m1_rsp_valid, m0_rsp_valid}, 32'h2);
        check("nb_rdata", m1_rsp_rdata, 32'h11111111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rams_sdp_arbiter.md
# rams_sdp_arbiter

Two-requester arbiter and sequencer for the single-clock simple-dual-port block RAM (one write port A, one registered read port B with 1-cycle latency). Writes from either requester go to port A and reads to port B, each port under its own round-robin grant, so a write from one requester and a read from the other complete in the same cycle. The read response is routed back to the requester that issued it. A same-cycle write/read to one address is bypassed so the reader always sees the newly written data. It sits between the core's data-memory path and the loader/debug path in front of one RAM instance.

## Interface
- DATA_WIDTH, 32, word width; equals RAM DATA_WIDTH
- ADDR_WIDTH, 10, address width; equals RAM ADDR_WIDTH
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req_valid / m1_req_valid  in  1  request present
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle (combinational grant)
- m0_req_we / m1_req_we  in  1  1 = write, 0 = read
- m0_req_addr / m1_req_addr  in  ADDR_WIDTH  word address
- m0_req_wdata / m1_req_wdata  in  DATA_WIDTH  write data
- m0_rsp_valid / m1_rsp_valid  out  1  read data valid, one pulse per accepted read
- m0_rsp_rdata / m1_rsp_rdata  out  DATA_WIDTH  read data
- ram_ena, ram_wea  out  1  RAM write enable pair (driven identically)
- ram_addra  out  ADDR_WIDTH  RAM write address
- ram_dia  out  DATA_WIDTH  RAM write data
- ram_enb  out  1  RAM read enable
- ram_addrb  out  ADDR_WIDTH  RAM read address
- ram_dob  in  DATA_WIDTH  RAM registered read data

## Operation
- Request classes: write = valid & we; read = valid & !we. Each requester presents one op per cycle.
- Write arbiter: candidates are the write-class requesters. A single candidate is granted. If both are candidates, the one not holding the write priority pointer loses. Grant sets ram_ena = ram_wea = 1 and muxes addr/wdata.
- Read arbiter: identical scheme on the read class with its own pointer. Grant sets ram_enb = 1 and muxes addr.
- Pointers: after a contested or uncontested grant, the pointer moves to the non-granted requester. It is unchanged when nothing is granted. Both pointers reset to m0.
- req_ready = granted by either arbiter; no grant without valid. An unaccepted request must be held stable by the requester.
- Ungranted RAM outputs: enables 0; addresses and data hold their previous values (no toggling).
- Response tracking: registers rd_pend (1 bit), rd_id (0/1), byp_hit (1 bit), byp_data (DATA_WIDTH).
- byp_hit is set when the write and read are granted in the same cycle with ram_addra == ram_addrb; byp_data then captures ram_dia.
- Next cycle: rsp_valid pulses on requester rd_id only. rsp_rdata = byp_hit ? byp_data : ram_dob, routed to both requesters' rdata; only rsp_valid qualifies it.
- No backpressure on responses: requesters must accept rsp in the pulse cycle.

## Timing
- Request to ready: 0 cycles (combinational on valid, we, pointers).
- Read accept (cycle N) -> rsp_valid in cycle N+1; throughput one read and one write per cycle.
- Write accepted in cycle N is visible to a read accepted in cycle N (bypass) or in N+1 and later (RAM).
- Reset values: rd_pend=0, rd_id=0, byp_hit=0, byp_data=0, both pointers=m0, all ram enables 0, ram addresses/data 0, rsp_valid 0.
- Reset asserted mid-operation: an in-flight read response is dropped (no rsp_valid after reset). The RAM's own synchronous rst clears its dob.
- Same requester writing and reading in one cycle is impossible by construction (single we bit).

## Structure
- Shared package rams_sdp_arb_pkg: REQ_M0/REQ_M1 id constants and the reset pointer value.
- One sub-module, rr_arb2: two-input round-robin arbiter with a registered pointer and async reset, instantiated twice (write and read).
- The top handles the muxing, response tracking and bypass. The RAM is instantiated outside the block.

## Test plan
- Reset then idle: all outputs 0, no rsp_valid for 10 cycles; assert rst mid-read, confirm no rsp_valid follows.
- m0 writes 0xDEADBEEF @0x005, then m1 reads @0x005 next cycle -> m1_rsp_valid one cycle later with 0xDEADBEEF; m0_rsp_valid stays 0.
- Same cycle: m0 writes 0x12345678 @0x3FF and m1 reads @0x3FF -> both ready=1; m1 rsp 0x12345678 via bypass. A later read of @0x3FF returns the same value from RAM.
- Both read continuously for 6 cycles at distinct preloaded addresses -> grants alternate m0, m1, m0, …; each rsp is correct and lands on the issuer.
- Both write continuously -> grants alternate starting with m0. The losing requester holds its request; the final RAM contents match the serialized order.
- m0 writes @0x010 while m1 reads @0x011 (different address) -> no bypass; m1 gets the old @0x011 value.
